button_event: RTL

Turns the clean, debounced pushbutton level from the demo's debounce stage into single-cycle event pulses in the `clk` domain: press, release, long-press, and an auto-repeating `step` strobe. It sits directly downstream of the debouncer. Its `step` output drives the manual single-step and clock-advance inputs of the CPU demo, so a held button keeps stepping at a fixed rate.

---
 rtl/button_event_pkg.sv | 15 +
 rtl/button_event.sv | 91 +++++++++
 2 files changed

// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared timing defaults and counter sizing for button_event
package button_event_pkg;

    // 100 MHz demo timing, in clk cycles
    localparam int DEMO_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEMO_REPEAT_CYCLES   = 10_000_000;
    localparam int DEMO_LONG_CYCLES     = 50_000_000;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/button_event.sv
// rtl/button_event.sv - debounced button level to press/release/long/auto-repeat step pulses
module button_event
    import button_event_pkg::*;
#(
    parameter int LONG_LIMIT    = DEMO_LONG_CYCLES,
    parameter int REPEAT_PERIOD = DEMO_REPEAT_CYCLES,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pbi,
    output logic press,
    output logic released,
    output logic long,
    output logic step,
    output logic held
);

    localparam int CW = cnt_width(LONG_LIMIT, REPEAT_PERIOD);
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_LIMIT - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESSED = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            press    <= 1'b0;
            released <= 1'b0;
            long     <= 1'b0;
            step     <= 1'b0;
            held     <= 1'b0;
        end else begin
            press    <= 1'b0;
            released <= 1'b0;
            long     <= 1'b0;
            step     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pbi) begin
                        state <= S_PRESSED;
                        count <= '0;
                        press <= 1'b1;
                        step  <= 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!pbi) begin
                        state    <= S_IDLE;
                        count    <= '0;
                        released <= 1'b1;
                    end else if (count == LONG_LAST) begin
                        state <= S_HELD;
                        count <= '0;
                        long  <= 1'b1;
                        step  <= REPEAT_EN;
                        held  <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_HELD: begin
                    // release wins over a repeat landing on the same edge
                    if (!pbi) begin
                        state    <= S_IDLE;
                        count    <= '0;
                        released <= 1'b1;
                        held     <= 1'b0;
                    end else if (REPEAT_EN && count == REPEAT_LAST) begin
                        count <= '0;
                        step  <= 1'b1;
                    end else if (REPEAT_EN) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    count <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule
